// File: rtl/speed_display_if.sv
// Display-side signal bundle: speed value and enable in, segment/anode drive and busy flag out.
// master = upstream measurement stage, slave = speed_display.
interface speed_display_if;
  logic [9:0] speed;
  logic       dig_show;
  logic [6:0] seg;
  logic [3:0] an;
  logic       conv_busy;

  modport master (output speed, dig_show, input seg, an, conv_busy);
  modport slave  (input speed, dig_show, output seg, an, conv_busy);
endinterface

// File: rtl/speed_display.sv
// Speed to 4-digit 7-segment display: serial double-dabble conversion committed 12 cycles after a change,
// multiplexed scan with registered seg/an (1 cycle). Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module speed_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  speed_display_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [9:0]    r_last_bin;
  logic [9:0]    r_shift;
  logic [15:0]   r_scratch;
  logic [15:0]   w_adj;
  logic [3:0]    r_cnt;
  logic          r_commit;
  logic [15:0]   r_disp_bcd;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_dig;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.speed != r_last_bin) w_next = SHIFT;
      SHIFT:   if (r_cnt == 4'd9) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble ahead of the left shift.
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < 4; k++) begin
      if (r_scratch[k*4 +: 4] >= 4'd5) w_adj[k*4 +: 4] = r_scratch[k*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_bin <= '0;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_commit   <= 1'b0;
      r_disp_bcd <= '0;
    end else begin
      r_commit <= (r_state == COMMIT);
      // Scratch is stable until the next IDLE load, so the delayed copy is always whole.
      if (r_commit) r_disp_bcd <= r_scratch;
      if (r_state == IDLE && bus.speed != r_last_bin) begin
        r_last_bin <= bus.speed;
        r_shift    <= bus.speed;
        r_scratch  <= '0;
        r_cnt      <= '0;
      end else if (r_state == SHIFT) begin
        r_scratch <= {w_adj[14:0], r_shift[9]};
        r_shift   <= {r_shift[8:0], 1'b0};
        r_cnt     <= r_cnt + 4'd1;
      end
    end
  end

  assign bus.conv_busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_dig <= '0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  always_comb begin
    case (r_dig)
      2'd0:    w_nib = r_disp_bcd[3:0];
      2'd1:    w_nib = r_disp_bcd[7:4];
      2'd2:    w_nib = r_disp_bcd[11:8];
      default: w_nib = r_disp_bcd[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (r_dig)
      2'd1:    w_blank = (r_disp_bcd[15:4] == 12'd0);
      2'd2:    w_blank = (r_disp_bcd[15:8] == 8'd0);
      2'd3:    w_blank = (r_disp_bcd[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else if (!bus.dig_show || w_blank) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= ~(4'b0001 << r_dig);
      r_seg <= f_seg(w_nib);
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;

endmodule
